// File: rtl/counting_ones_seq.sv
// Sequential population counter: a word is accepted, counted CHUNK bits per
// clock, and the result (count, parity, zero flag) is held until consumed.
//
// state | meaning
// IDLE  | ready for a new word; in_ready high
// COUNT | consuming the shift register one chunk per clock
// DONE  | result valid; waiting for out_ready
module counting_ones_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               a,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(WIDTH+1)-1:0]     y,
   output logic                           parity,
   output logic                           zero
);

   localparam int NCYC = WIDTH / CHUNK;
   localparam int CW   = $clog2(WIDTH + 1);
   localparam int PW   = $clog2(CHUNK + 1);
   // A single-chunk word still needs a one-bit counter to keep the types legal.
   localparam int CNTW = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  shift_q;
   logic [CW-1:0]     acc_q;
   logic [CNTW-1:0]   cnt_q;
   logic [CW-1:0]     res_q;
   logic              parity_q;
   logic              zero_q;
   logic              in_ready_q;
   logic              out_valid_q;

   logic [PW-1:0]     chunk_pop_d;
   logic [CW-1:0]     acc_d;

   // Popcount of the low chunk, zero-extended into the accumulator sum.
   always_comb begin
      chunk_pop_d = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pop_d = chunk_pop_d + PW'(shift_q[i]);
      end
      acc_d = acc_q + CW'(chunk_pop_d);
   end

   // Control FSM with datapath and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         parity_q    <= 1'b0;
         zero_q      <= 1'b1;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  shift_q    <= a;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= COUNT;
               end
            end
            COUNT: begin
               shift_q <= shift_q >> CHUNK;
               acc_q   <= acc_d;
               cnt_q   <= cnt_q + CNTW'(1);
               if (cnt_q == LAST_CHUNK) begin
                  res_q       <= acc_d;
                  parity_q    <= acc_d[0];
                  zero_q      <= (acc_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = res_q;
   assign parity    = parity_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_counting_ones_seq.sv
// Bench for counting_ones_seq: directed runs on 16/4, 8/1 and 8/8 instances,
// random handshake regression on a 32/8 instance, scoreboard-checked results.
module tb_counting_ones_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // 16/4 instance
   logic        v0 = 0, r0, ov0, or0 = 0, p0, z0;
   logic [15:0] a0 = '0;
   logic [4:0]  y0;
   // 8/1 instance
   logic        v1 = 0, r1, ov1, or1 = 0, p1, z1;
   logic [7:0]  a1 = '0;
   logic [3:0]  y1;
   // 8/8 instance
   logic        v2 = 0, r2, ov2, or2 = 0, p2, z2;
   logic [7:0]  a2 = '0;
   logic [3:0]  y2;
   // 32/8 instance
   logic        v3 = 0, r3, ov3, or3 = 0, p3, z3;
   logic [31:0] a3 = '0;
   logic [5:0]  y3;

   counting_ones_seq #(.WIDTH(16), .CHUNK(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .a(a0),
      .out_valid(ov0), .out_ready(or0), .y(y0), .parity(p0), .zero(z0));
   counting_ones_seq #(.WIDTH(8), .CHUNK(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .a(a1),
      .out_valid(ov1), .out_ready(or1), .y(y1), .parity(p1), .zero(z1));
   counting_ones_seq #(.WIDTH(8), .CHUNK(8)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .a(a2),
      .out_valid(ov2), .out_ready(or2), .y(y2), .parity(p2), .zero(z2));
   counting_ones_seq #(.WIDTH(32), .CHUNK(8)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .a(a3),
      .out_valid(ov3), .out_ready(or3), .y(y3), .parity(p3), .zero(z3));

   function automatic int popcnt(input logic [31:0] v);
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int q0[$];
   int q3[$];
   int acc3  = 0;
   int pops3 = 0;

   // Scoreboard for the 16/4 instance: push on accept, pop on transfer.
   always @(negedge clk) begin
      if (rst) q0.delete();
      else begin
         if (ov0 && or0) begin
            chk("sb0_pending", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
               int e;
               e = q0.pop_front();
               chk("sb0_y", 32'(y0), e);
               chk("sb0_parity", 32'(p0), e & 1);
               chk("sb0_zero", 32'(z0), (e == 0) ? 1 : 0);
            end
         end
         if (v0 && r0) q0.push_back(popcnt(32'(a0)));
      end
   end

   // Scoreboard for the 32/8 instance.
   always @(negedge clk) begin
      if (rst) q3.delete();
      else begin
         if (ov3 && or3) begin
            pops3++;
            chk("sb3_pending", int'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
               int e;
               e = q3.pop_front();
               chk("sb3_y", 32'(y3), e);
               chk("sb3_parity", 32'(p3), e & 1);
            end
         end
         if (v3 && r3) begin
            q3.push_back(popcnt(a3));
            acc3++;
         end
      end
   end

   // One word through the 16/4 instance, optionally held in DONE for hold cycles.
   task automatic run0(input logic [15:0] d, input int hold, output time t_acc);
      int n;
      int e;
      e  = popcnt(32'(d));
      v0 = 1'b1;
      a0 = d;
      @(posedge clk);
      t_acc = $time;
      #1 v0 = 1'b0;
      a0 = 16'h5A5A;
      chk("busy_in_ready", 32'(r0), 0);
      n = 0;
      while (!ov0 && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency16", n, 4);
      for (int k = 0; k < hold; k++) begin
         chk("hold_in_ready", 32'(r0), 0);
         chk("hold_y", 32'(y0), e);
         v0 = 1'b1;
         a0 = 16'hFFFF;
         @(posedge clk);
         #1 v0 = 1'b0;
      end
      chk("done_valid", 32'(ov0), 1);
      chk("done_y", 32'(y0), e);
      or0 = 1'b1;
      @(posedge clk);
      #1 or0 = 1'b0;
      chk("ready_after_xfer", 32'(r0), 1);
      chk("idle_out_valid", 32'(ov0), 0);
   endtask

   initial begin
      time t0, t1, t2, t3, t4;
      int  n;
      int  stale;
      int  cyc;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_y", 32'(y0), 0);
      chk("rst_parity", 32'(p0), 0);
      chk("rst_zero", 32'(z0), 1);
      chk("rst_out_valid", 32'(ov0), 0);
      chk("rst_in_ready", 32'(r0), 1);

      run0(16'hFFFF, 0, t0);
      run0(16'h0000, 0, t1);
      run0(16'h8001, 0, t2);
      chk("spacing_a", int'((t1 - t0) / 10), 6);
      chk("spacing_b", int'((t2 - t1) / 10), 6);

      run0(16'h00F3, 5, t3);
      run0(16'h1234, 0, t4);

      // Abort a word on its second COUNT cycle.
      v0 = 1'b1;
      a0 = 16'hFFFF;
      @(posedge clk);
      #1 v0 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_in_ready", 32'(r0), 1);
      chk("abort_out_valid", 32'(ov0), 0);
      chk("abort_y", 32'(y0), 0);
      chk("abort_zero", 32'(z0), 1);
      stale = 0;
      repeat (12) begin
         @(posedge clk);
         #1 if (ov0) stale = 1;
      end
      chk("no_stale_result", stale, 0);
      run0(16'hA5A5, 0, t0);

      // 8/1 instance
      v1 = 1'b1;
      a1 = 8'hB7;
      @(posedge clk);
      #1 v1 = 1'b0;
      n = 0;
      while (!ov1 && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency8x1", n, 8);
      chk("y8x1", 32'(y1), 6);
      chk("parity8x1", 32'(p1), 0);
      chk("zero8x1", 32'(z1), 0);
      or1 = 1'b1;
      @(posedge clk);
      #1 or1 = 1'b0;
      chk("ready8x1", 32'(r1), 1);

      // 8/8 instance
      v2 = 1'b1;
      a2 = 8'h80;
      @(posedge clk);
      #1 v2 = 1'b0;
      n = 0;
      while (!ov2 && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency8x8", n, 1);
      chk("y8x8", 32'(y2), 1);
      chk("parity8x8", 32'(p2), 1);
      or2 = 1'b1;
      @(posedge clk);
      #1 or2 = 1'b0;
      chk("ready8x8", 32'(r2), 1);

      // Random handshakes on the 32/8 instance.
      cyc = 0;
      while (acc3 < 1000 && cyc < 40000) begin
         v3  = 1'($urandom_range(0, 1));
         a3  = $urandom;
         or3 = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 cyc++;
      end
      v3  = 1'b0;
      or3 = 1'b1;
      cyc = 0;
      while (q3.size() > 0 && cyc < 100) begin
         @(posedge clk);
         #1 cyc++;
      end
      repeat (10) @(posedge clk);
      #1 or3 = 1'b0;
      chk("rand_accepted", acc3, 1000);
      chk("rand_delivered", pops3, 1000);
      chk("rand_drained", q3.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counting_ones_seq.md
COUNTING_ONES_SEQ -- requirements
Module: counting_ones_seq

Interface
REQ-001 Parameter WIDTH, default 16, input word width in bits; SHALL be >= 1.
REQ-002 Parameter CHUNK, default 4, bits counted per clock; SHALL be >= 1 and SHALL divide WIDTH exactly.
REQ-003 Derived constants SHALL be NCYC = WIDTH/CHUNK and CW = $clog2(WIDTH+1); neither SHALL be exposed as a port.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input word a is presented.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 a  input  WIDTH  word to count.
REQ-010 out_valid  output  1  result y, parity and zero are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 y  output  CW  number of 1 bits in the accepted word.
REQ-013 parity  output  1  y[0], the XOR of all bits of the accepted word.
REQ-014 zero  output  1  high when y == 0.

Function
REQ-015 FSM states SHALL be IDLE, COUNT and DONE.
REQ-016 IDLE: in_ready=1 and out_valid=0.
- An edge with in_valid=1 SHALL capture a into a WIDTH-bit shift register.
- The same edge SHALL clear the accumulator and the chunk counter and enter COUNT.
REQ-017 COUNT: in_ready=0 and out_valid=0.
- Each edge SHALL add the popcount of shift register bits [CHUNK-1:0] to the accumulator.
- The same edge SHALL shift the register right by CHUNK and increment the chunk counter.
REQ-018 The edge that processes chunk NCYC-1 SHALL write the final sum and enter DONE.
REQ-019 Latency: out_valid SHALL rise exactly NCYC clock edges after the accepting edge.
- NCYC=1 (CHUNK=WIDTH) gives one cycle.
REQ-020 DONE: out_valid=1 and in_ready=0.
- y, parity and zero SHALL hold stable until the edge where out_ready=1.
- That edge SHALL return the FSM to IDLE.
REQ-021 A cycle with out_valid and out_ready both high completes the transfer.
- in_ready SHALL be 1 on the next cycle.
- Back-to-back throughput SHALL be one word per NCYC+2 cycles.
REQ-022 in_ready SHALL depend only on state, never combinationally on out_ready or in_valid.
REQ-023 in_valid and a SHALL be ignored whenever in_ready=0; no queuing.
REQ-024 The accumulator SHALL be CW bits wide.
- The all-ones input SHALL give y=WIDTH with no overflow or wrap.
- The per-chunk popcount SHALL use $clog2(CHUNK+1) bits, zero-extended before the add.
REQ-025 y, parity and zero SHALL be registered outputs driven only from the result register.
- Outside DONE their value is don't-care but SHALL be stable.
REQ-026 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE and clear the shift register, accumulator, chunk counter and result register.
- Outputs after reset: y=0, parity=0, zero=1, out_valid=0, in_ready=1.
REQ-028 rst SHALL take priority over every handshake in the same cycle.
- Reset during COUNT or DONE SHALL discard the word in progress.
- No out_valid SHALL follow for a discarded word.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 WIDTH=16, CHUNK=4, a=16'hFFFF accepted -> out_valid 4 edges later, y=16, parity=0, zero=0.
REQ-031 WIDTH=16, CHUNK=4:
- a=16'h0000 -> y=0, parity=0, zero=1.
- a=16'h8001 -> y=2.
- Each with out_ready=1, next word accepted 6 cycles after the previous accept.
REQ-032 Backpressure: a=16'h00F3 with out_ready=0 for 5 cycles in DONE -> y=6 stable throughout.
- in_ready=0 throughout.
- in_valid pulses with a=16'hFFFF during the wait are ignored.
- After out_ready=1 the next accepted word counts correctly.
REQ-033 Reset asserted on the 2nd COUNT cycle -> next cycle in_ready=1, out_valid=0, y=0, zero=1.
- No stale result appears afterwards.
REQ-034 Parameter sweep:
- WIDTH=8, CHUNK=1, a=8'hB7 -> y=6, parity=0, out_valid after 8 edges.
- WIDTH=8, CHUNK=8, a=8'h80 -> y=1, parity=1, out_valid after 1 edge.
REQ-035 Random regression, 1000 words, WIDTH=32, CHUNK=8, random in_valid/out_ready -> every y matches a reference popcount.
- No word lost or duplicated.
